// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

  localparam int XLEN_DEF            = 64;
  localparam int IMEM_DEPTH_DEF      = 2048;
  localparam int IMEM_DATA_WIDTH_DEF = 32;
  localparam int INST_BYTES          = 4;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: instruction-memory port plus the IF/ID handshake.
//
// Handshake: an instruction transfers on a cycle where o_inst_valid and
// i_inst_ready are both high. While o_inst_valid is high and i_inst_ready is
// low, o_inst/o_inst_pc stay stable until the transfer, a redirect or a reset.
// Memory port: i_im_rdata carries the word addressed by o_im_addr one cycle
// after o_im_en was high.
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int XLEN            = XLEN_DEF,
  parameter int IMEM_ADDR_WIDTH = $clog2(IMEM_DEPTH_DEF),
  parameter int IMEM_DATA_WIDTH = IMEM_DATA_WIDTH_DEF
);
  logic                       o_im_en;
  logic [IMEM_ADDR_WIDTH-1:0] o_im_addr;
  logic [IMEM_DATA_WIDTH-1:0] i_im_rdata;
  logic                       o_inst_valid;
  logic                       i_inst_ready;
  logic [IMEM_DATA_WIDTH-1:0] o_inst;
  logic [XLEN-1:0]            o_inst_pc;

  modport master (
    output o_im_en, o_im_addr, o_inst_valid, o_inst, o_inst_pc,
    input  i_im_rdata, i_inst_ready
  );

  modport slave (
    input  o_im_en, o_im_addr, o_inst_valid, o_inst, o_inst_pc,
    output i_im_rdata, i_inst_ready
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for {inst, pc}. Captures a memory response that
// decode could not take, and releases it once decode accepts.
module fetch_skid_buf #(
  parameter int XLEN = 64,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            resp_valid_i,
  input  logic            ready_i,
  input  logic [DW-1:0]   inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic            valid_nxt_o,
  output logic [DW-1:0]   inst_o,
  output logic [XLEN-1:0] pc_o
);
  logic            valid_q, valid_d;
  logic [DW-1:0]   inst_q;
  logic [XLEN-1:0] pc_q;
  logic            capture, drain;

  assign capture = resp_valid_i && !ready_i && !valid_q && !flush_i;
  assign drain   = valid_q && ready_i;

  // Occupancy next state: flush beats capture, capture beats release.
  always_comb begin
    valid_d = valid_q;
    if (flush_i)      valid_d = 1'b0;
    else if (capture) valid_d = 1'b1;
    else if (drain)   valid_d = 1'b0;
  end

  // Storage: payload is only written on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      if (capture) begin
        inst_q <= inst_i;
        pc_q   <= pc_i;
      end
    end
  end

  assign valid_o     = valid_q;
  assign valid_nxt_o = valid_d;
  assign inst_o      = inst_q;
  assign pc_o        = pc_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives a 1-cycle-latency
// instruction memory and presents instructions to decode over valid/ready.
// Optional build macro: FETCH_CTRL_PERF_EN enables the performance counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEF,
  parameter int              IMEM_DEPTH      = IMEM_DEPTH_DEF,
  parameter int              IMEM_ADDR_WIDTH = $clog2(IMEM_DEPTH),
  parameter int              IMEM_DATA_WIDTH = IMEM_DATA_WIDTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_redirect_valid,
  input  logic [XLEN-1:0]  i_redirect_pc,
  input  logic             i_halt,
  output logic             o_halted,
  output logic [63:0]      o_perf_fetched,
  output logic [63:0]      o_perf_stall,
  output fetch_state_e     o_dbg_state,
  fetch_ctrl_if.master     bus
);
  fetch_state_e              state_q;
  logic                      halted_q;
  logic [XLEN-1:0]           fetch_pc_q, inflight_pc_q;
  logic                      inflight_q;
  logic                      redirect, run, issue;
  logic [XLEN-1:0]           redirect_pc, issue_pc;
  logic                      buf_valid, buf_valid_nxt;
  logic [IMEM_DATA_WIDTH-1:0] buf_inst;
  logic [XLEN-1:0]           buf_pc;

  // Reset wins over redirect; the low target bits are forced to zero.
  assign redirect    = i_redirect_valid && !rst;
  assign redirect_pc = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign run         = (state_q == ST_RUN) && !rst;

  // Issue only when a response has somewhere to go next cycle; a redirect in
  // RUN always issues since it squashes everything that is pending.
  assign issue    = run && (redirect ||
                    (!buf_valid && !(inflight_q && !bus.i_inst_ready)));
  assign issue_pc = redirect ? redirect_pc : fetch_pc_q;

  assign bus.o_im_en   = issue;
  assign bus.o_im_addr = issue_pc[IMEM_ADDR_WIDTH+1:2];

  fetch_skid_buf #(
    .XLEN (XLEN),
    .DW   (IMEM_DATA_WIDTH)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect),
    .resp_valid_i (inflight_q),
    .ready_i      (bus.i_inst_ready),
    .inst_i       (bus.i_im_rdata),
    .pc_i         (inflight_pc_q),
    .valid_o      (buf_valid),
    .valid_nxt_o  (buf_valid_nxt),
    .inst_o       (buf_inst),
    .pc_o         (buf_pc)
  );

  // Output mux: buffered entry first, otherwise the arriving response passes straight through.
  always_comb begin
    bus.o_inst    = '0;
    bus.o_inst_pc = '0;
    if (buf_valid) begin
      bus.o_inst    = buf_inst;
      bus.o_inst_pc = buf_pc;
    end else if (inflight_q) begin
      bus.o_inst    = bus.i_im_rdata;
      bus.o_inst_pc = inflight_pc_q;
    end
    bus.o_inst_valid = !rst && !redirect && (buf_valid || inflight_q);
  end

  // Fetch PC and in-flight tracking; any arriving response is either taken or buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= issue_pc;
        fetch_pc_q    <= issue_pc + XLEN'(INST_BYTES);
      end else if (redirect) begin
        fetch_pc_q <= redirect_pc;
      end
    end
  end

  // Run/drain/halt sequencing. DRAIN never issues, so it is drained once the buffer empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q  <= i_halt ? ST_DRAIN : ST_RUN;
          halted_q <= 1'b0;
        end
        ST_RUN: begin
          if (i_halt) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!i_halt) begin
            state_q <= ST_RUN;
          end else if (!buf_valid_nxt) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!i_halt) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_BOOT;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_halted    = halted_q;
  assign o_dbg_state = state_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [63:0] perf_fetched_q, perf_stall_q;

  // Accepted-instruction and backpressure-cycle counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (bus.o_inst_valid && bus.i_inst_ready)  perf_fetched_q <= perf_fetched_q + 64'd1;
      if (bus.o_inst_valid && !bus.i_inst_ready) perf_stall_q   <= perf_stall_q + 64'd1;
    end
  end

  assign o_perf_fetched = perf_fetched_q;
  assign o_perf_stall   = perf_stall_q;
`else
  assign o_perf_fetched = '0;
  assign o_perf_stall   = '0;
`endif

`ifndef SYNTHESIS
  // Redirect targets are expected to be word-aligned.
  a_redirect_aligned: assert property (@(posedge clk) disable iff (rst)
    i_redirect_valid |-> (i_redirect_pc[1:0] == 2'b00));
`endif
endmodule
